// File: rtl/mem_dma_copy_pkg.sv
// Shared types and constants for the word-copy DMA engine.
package mem_dma_copy_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_FIN  = 2'd3
   } state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ABORT   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   localparam logic [3:0] WSTRB_FULL = 4'hF;

endpackage

// File: rtl/mem_dma_copy.sv
// Word-by-word memory copy engine driving a native valid/ready memory bus.
// Alternates read and write transactions until done, aborted or timed out.
module mem_dma_copy
   import mem_dma_copy_pkg::*;
#(
   parameter int LEN_W    = 16,
   parameter int MAX_WAIT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_valid,
   output logic             mem_instr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_ready,
   input  logic [31:0]      mem_rdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_e            state_q, state_d;
   logic [31:0]       src_q, src_d;
   logic [31:0]       dst_q, dst_d;
   logic [31:0]       data_q, data_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        status_q, status_d;
   logic              abort_q, abort_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      data_d   = data_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      abort_d  = abort_q;
      wait_d   = wait_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d    = src_addr & ~32'h3;
               dst_d    = dst_addr & ~32'h3;
               len_d    = len_words;
               cnt_d    = '0;
               status_d = ST_OK;
               abort_d  = 1'b0;
               wait_d   = '0;
               state_d  = (len_words == '0) ? S_FIN : S_RD;
            end
         end
         S_RD, S_WR: begin
            if (abort) abort_d = 1'b1;
            if (mem_ready) begin
               wait_d = '0;
               if (state_q == S_RD) begin
                  data_d  = mem_rdata;
                  state_d = S_WR;
               end else begin
                  src_d = src_q + 32'd4;
                  dst_d = dst_q + 32'd4;
                  cnt_d = cnt_q + LEN_W'(1);
                  // abort is honoured only at a word boundary
                  if (abort_q || abort) begin
                     status_d = ST_ABORT;
                     state_d  = S_FIN;
                  end else if (cnt_q + LEN_W'(1) == len_q) begin
                     state_d = S_FIN;
                  end else begin
                     state_d = S_RD;
                  end
               end
            end else if (wait_q == WAIT_LAST) begin
               wait_d   = '0;
               status_d = ST_TIMEOUT;
               state_d  = S_FIN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         data_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         status_q <= ST_OK;
         abort_q  <= 1'b0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         data_q   <= data_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
         abort_q  <= abort_d;
         wait_q   <= wait_d;
      end
   end

   // bus outputs decode from registered state so they stay put while waiting
   assign mem_valid  = (state_q == S_RD) || (state_q == S_WR);
   assign mem_instr  = 1'b0;
   assign mem_addr   = (state_q == S_RD) ? src_q :
                       (state_q == S_WR) ? dst_q : 32'h0;
   assign mem_wdata  = (state_q == S_WR) ? data_q : 32'h0;
   assign mem_wstrb  = (state_q == S_WR) ? WSTRB_FULL : 4'h0;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_FIN);
   assign status     = status_q;
   assign words_done = cnt_q;

endmodule

// File: tb/tb_mem_dma_copy.sv
// Randomized scoreboard bench for mem_dma_copy with a behavioural memory
// responder and a copy-level reference model.
module tb_mem_dma_copy;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len_words;
   logic        busy;
   logic        done;
   logic [1:0]  status;
   logic [15:0] words_done;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_dma_copy #(.LEN_W(16), .MAX_WAIT(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
      .busy(busy), .done(done), .status(status), .words_done(words_done),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      logic [1:0]  st;
      logic [15:0] wd;
   } done_t;

   txn_t  exp_q[$];
   done_t done_q[$];

   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   int compared = 0;
   int mismatched = 0;

   int rd_min = 0, rd_max = 0, wr_min = 0, wr_max = 0;
   bit never_rd = 0, never_wr = 0;
   int valid_cycles = 0;

   function automatic logic [31:0] init_word(logic [31:0] a);
      return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [31:0] bus_rd(logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: copy n words, src word i lands at dst word i.
   task automatic model_copy(logic [31:0] src, logic [31:0] dst,
                             int len, int abort_idx, bit tmo);
      logic [31:0] s, d, a, v;
      int n;
      txn_t t;
      done_t r;
      s = src & ~32'h3;
      d = dst & ~32'h3;
      if (tmo) begin
         r.st = 2'b10; r.wd = 16'd0;
         done_q.push_back(r);
         return;
      end
      n = len;
      if (abort_idx >= 0 && abort_idx < len) n = abort_idx + 1;
      for (int i = 0; i < n; i++) begin
         a = s + 32'(4 * i);
         v = ref_rd(a);
         t.wr = 0; t.addr = a; t.data = v;
         exp_q.push_back(t);
         t.wr = 1; t.addr = d + 32'(4 * i); t.data = v;
         exp_q.push_back(t);
         ref_mem[t.addr] = v;
      end
      r.st = (abort_idx >= 0 && abort_idx < len) ? 2'b01 : 2'b00;
      r.wd = 16'(n);
      done_q.push_back(r);
   endtask

   // Responder and monitor: decides mem_ready away from the active edge,
   // so a ready chosen here is the handshake of the coming rising edge.
   int cnt = 0;
   int cur_d = 0;
   bit prev_wait = 0;
   bit is_wr;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_wstrb;

   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mem_ready = 1'b0;
            cnt = 0;
            prev_wait = 0;
         end else if (mem_valid) begin
            valid_cycles++;
            is_wr = (mem_wstrb != 4'h0);
            if (prev_wait) begin
               check("hold_addr", mem_addr, p_addr);
               check("hold_wdata_wstrb", {mem_wdata, mem_wstrb},
                     {p_wdata, p_wstrb});
            end
            if (cnt == 0) begin
               if (is_wr)
                  cur_d = never_wr ? 1 << 30 : $urandom_range(wr_max, wr_min);
               else
                  cur_d = never_rd ? 1 << 30 : $urandom_range(rd_max, rd_min);
            end
            mem_ready = (cnt >= cur_d);
            mem_rdata = is_wr ? $urandom : bus_rd(mem_addr);
            cnt++;
            if (mem_ready) begin
               if (exp_q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_txn: got addr %0h wr %0d expected none",
                           mem_addr, is_wr);
               end else begin
                  txn_t e;
                  e = exp_q.pop_front();
                  check("txn_kind", is_wr, e.wr);
                  check("txn_addr", mem_addr, e.addr);
                  if (is_wr)
                     check("txn_wdata_wstrb", {mem_wdata, mem_wstrb},
                           {e.data, 4'hF});
               end
               if (is_wr) mem[mem_addr] = mem_wdata;
               cnt = 0;
               prev_wait = 0;
            end else begin
               prev_wait = 1;
               p_addr = mem_addr;
               p_wdata = mem_wdata;
               p_wstrb = mem_wstrb;
            end
         end else begin
            mem_ready = 1'b0;
            cnt = 0;
            prev_wait = 0;
         end
         if (done) begin
            if (done_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_done: got status %0d expected no done",
                        status);
            end else begin
               done_t r;
               r = done_q.pop_front();
               check("done_status", status, r.st);
               check("done_words", words_done, r.wd);
            end
         end
      end
   end

   task automatic run(logic [31:0] src, logic [31:0] dst, int len,
                      int abort_idx, bit tmo, int exp_cyc,
                      bit abort_with_start, bit start_busy);
      int cyc;
      bit aborted;
      logic [31:0] s;
      s = src & ~32'h3;
      model_copy(src, dst, len, abort_idx, tmo);
      @(negedge clk);
      src_addr = src;
      dst_addr = dst;
      len_words = 16'(len);
      start = 1'b1;
      abort = abort_with_start;
      valid_cycles = 0;
      cyc = 0;
      aborted = 0;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = start_busy && (cyc == 2);
         len_words = 16'($urandom_range(1, 9));
         abort = 1'b0;
         if (cyc == 1) check("busy_after_start", busy, 1'b1);
         if (abort_idx >= 0 && !aborted && mem_valid && mem_wstrb == 4'h0 &&
             mem_addr == s + 32'(4 * abort_idx)) begin
            abort = 1'b1;
            aborted = 1;
         end
         if (done) break;
      end
      start = 1'b0;
      abort = 1'b0;
      if (!done) check("done_seen", done, 1'b1);
      if (exp_cyc >= 0) check("done_latency", cyc, exp_cyc);
      @(negedge clk);
      check("done_one_pulse", {busy, done}, 2'b00);
      check("all_txns_seen", exp_q.size(), 0);
   endtask

   task automatic set_delay(int rmin, int rmax, int wmin, int wmax);
      rd_min = rmin; rd_max = rmax; wr_min = wmin; wr_max = wmax;
   endtask

   initial begin
      int k;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      src_addr = 32'h0;
      dst_addr = 32'h0;
      len_words = 16'h0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {mem_valid, mem_instr, mem_addr, mem_wstrb, busy, done,
             status, words_done},
            64'h0);
      check("reset_wdata", mem_wdata, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      set_delay(0, 0, 0, 0);
      run(32'h100, 32'h200, 3, -1, 0, 7, 0, 0);
      check("ok_hold", {status, words_done}, {2'b00, 16'd3});

      set_delay(5, 5, 5, 5);
      run(32'h300, 32'h400, 1, -1, 0, -1, 0, 0);
      check("copied_word", bus_rd(32'h400), init_word(32'h300));

      set_delay(1, 3, 1, 3);
      run(32'h500, 32'h600, 4, 1, 0, -1, 0, 0);
      repeat (3) @(negedge clk);
      check("abort_hold", {status, words_done}, {2'b01, 16'd2});

      never_rd = 1;
      run(32'h700, 32'h800, 2, -1, 1, -1, 0, 0);
      check("timeout_valid_cycles", valid_cycles, 8);
      never_rd = 0;

      set_delay(0, 2, 0, 2);
      run(32'hFFFF_FFFC, 32'h900, 2, -1, 0, -1, 0, 0);
      run(32'hA00, 32'hB00, 0, -1, 0, 1, 0, 0);
      check("len0_no_bus", valid_cycles, 0);

      for (int i = 0; i < 8; i++) begin
         int len, ai;
         len = $urandom_range(1, 6);
         ai = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         set_delay(0, $urandom_range(0, 3), 0, $urandom_range(0, 3));
         run($urandom & 32'h0000_FFFF, 32'h0001_0000 | ($urandom & 32'hFFFF),
             len, ai, 0, -1, 0, 1);
      end

      set_delay(0, 0, 0, 0);
      never_wr = 1;
      model_copy(32'hC00, 32'hD00, 3, -1, 0);
      @(negedge clk);
      src_addr = 32'hC00;
      dst_addr = 32'hD00;
      len_words = 16'd3;
      start = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end while (!(mem_valid && mem_wstrb == 4'hF) && k < 20);
      check("reached_wr", mem_wstrb, 4'hF);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_reset_outputs",
            {mem_valid, mem_addr, mem_wstrb, busy, done, status, words_done},
            64'h0);
      check("async_reset_wdata", mem_wdata, 32'h0);
      exp_q.delete();
      done_q.delete();
      never_wr = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_idle", {busy, done}, 2'b00);
      run(32'h100, 32'h200, 3, -1, 0, 7, 1, 0);
      check("post_reset_result", {status, words_done}, {2'b00, 16'd3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
